mult_div_unit: RTL and testbench

//   Multicycle MULT/DIV execution unit of the multicycle MIPS core. It sits between
//   the A/B operand registers and the HI/LO registers. The control unit starts an

---
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed MULT/DIV unit feeding the HI/LO registers
// Radix-2 Booth multiply and restoring divide with a sign fix-up cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ready,
  output logic             busy,
  output logic             div_zero
);

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] lo_w_q, lo_w_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_rem_q, neg_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             ready_q, ready_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   a_sx, booth_sum, rem_sh, rem_sub;

  // acc doubles as the partial remainder and lo_w as the quotient during DIV.
  always_comb begin
    a_abs   = a[WIDTH-1] ? -a : a;
    b_abs   = b[WIDTH-1] ? -b : b;
    a_sx    = {opnd_q[WIDTH-1], opnd_q};
    rem_sh  = {acc_q[WIDTH-1:0], lo_w_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, opnd_q};
    case ({lo_w_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + a_sx;
      2'b10:   booth_sum = acc_q - a_sx;
      default: booth_sum = acc_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_w_d    = lo_w_q;
    qm1_d     = qm1_q;
    opnd_d    = opnd_q;
    neg_rem_d = neg_rem_q;
    neg_quo_d = neg_quo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    ready_d   = 1'b0;
    dz_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mult_start) begin
          acc_d   = '0;
          lo_w_d  = b;
          qm1_d   = 1'b0;
          opnd_d  = a;
          cnt_d   = '0;
          state_d = S_MULT;
        end else if (div_start) begin
          if (b == '0) begin
            dz_d = 1'b1;
          end else begin
            acc_d     = '0;
            lo_w_d    = a_abs;
            opnd_d    = b_abs;
            neg_rem_d = a[WIDTH-1];
            neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
            cnt_d     = '0;
            state_d   = S_DIV;
          end
        end
      end
      S_MULT: begin
        acc_d  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        lo_w_d = {booth_sum[0], lo_w_q[WIDTH-1:1]};
        qm1_d  = lo_w_q[0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DIV: begin
        if (rem_sh >= {1'b0, opnd_q}) begin
          acc_d  = rem_sub;
          lo_w_d = {lo_w_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d  = rem_sh;
          lo_w_d = {lo_w_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (neg_quo_q) lo_w_d = -lo_w_q;
        if (neg_rem_q) acc_d = {1'b0, -acc_q[WIDTH-1:0]};
        state_d = S_DONE;
      end
      S_DONE: begin
        hi_d    = acc_q[WIDTH-1:0];
        lo_d    = lo_w_q;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_w_q    <= '0;
      qm1_q     <= 1'b0;
      opnd_q    <= '0;
      neg_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      ready_q   <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lo_w_q    <= lo_w_d;
      qm1_q     <= qm1_d;
      opnd_q    <= opnd_d;
      neg_rem_q <= neg_rem_d;
      neg_quo_q <= neg_quo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      ready_q   <= ready_d;
      dz_q      <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign ready    = ready_q;
  assign div_zero = dz_q;
  assign busy     = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIX);

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed bench for mult_div_unit with an arithmetic reference model
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo;
  logic        ready, busy, div_zero;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .a(a), .b(b), .hi(hi), .lo(lo), .ready(ready), .busy(busy), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: result from plain 64-bit signed arithmetic, timing as a countdown.
  int                 m_left = 0;
  logic [31:0]        m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  logic               exp_ready = 1'b0, exp_dz = 1'b0;
  logic signed [63:0] sa, sb, sp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0; m_hi = '0; m_lo = '0; exp_ready = 1'b0; exp_dz = 1'b0;
    end else begin
      exp_ready = 1'b0;
      exp_dz = 1'b0;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          exp_ready = 1'b1; m_hi = r_hi; m_lo = r_lo;
        end
      end else if (mult_start) begin
        sp = sa * sb;
        r_hi = sp[63:32]; r_lo = sp[31:0]; m_left = 33;
      end else if (div_start) begin
        if (b == 32'd0) exp_dz = 1'b1;
        else begin
          sp = sa / sb; r_lo = sp[31:0];
          sp = sa % sb; r_hi = sp[31:0];
          m_left = 34;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_hi", 64'(hi), 64'(m_hi));
    check("cyc_lo", 64'(lo), 64'(m_lo));
    check("cyc_ready", 64'(ready), 64'(exp_ready));
    check("cyc_busy", 64'(busy), 64'(m_left >= 2));
    check("cyc_div_zero", 64'(div_zero), 64'(exp_dz));
  end

  task automatic run_op(input string name, input bit mul, input bit dv,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat, input bit repulse);
    int n;
    a = av; b = bv; mult_start = mul; div_start = dv;
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0; a = $urandom; b = $urandom;
    n = 0;
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
      mult_start = repulse && (n == 5);
      div_start = mult_start;
    end
    check({name, "_latency"}, 64'(n), 64'(elat));
    check({name, "_hi"}, 64'(hi), 64'(ehi));
    check({name, "_lo"}, 64'(lo), 64'(elo));
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_flags", 64'({ready, busy, div_zero}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("m7xm3", 1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 0);
    run_op("mminxmin", 1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 0);
    run_op("mminx1", 1, 0, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 33, 0);
    run_op("mm1xm1", 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 33, 1);
    run_op("dm7d2", 0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 0);
    run_op("d7dm2", 0, 1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 34, 0);
    run_op("dm100dm7", 0, 1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 34, 1);
    run_op("d95d10", 0, 1, 32'd95, 32'd10, 32'd5, 32'd9, 34, 0);

    a = 32'h1234; b = 32'd0; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    check("dz_pulse", 64'(div_zero), 64'd1);
    check("dz_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("dz_clear", 64'(div_zero), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    check("dz_no_ready", 64'(seen), 64'd0);
    check("dz_hi_kept", 64'(hi), 64'd5);
    check("dz_lo_kept", 64'(lo), 64'd9);

    run_op("dmindm1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 34, 0);
    run_op("both", 1, 1, 32'd6, 32'd7, 32'd0, 32'd42, 33, 0);

    a = 32'd5; b = 32'd6; mult_start = 1'b1;
    @(negedge clk);
    mult_start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_ready", 64'(ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("m3x4", 1, 0, 32'd3, 32'd4, 32'd0, 32'd12, 33, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
